// File: rtl/apb_master_bridge.sv
// APB initiator: converts single-beat local register requests into APB
// SETUP/ACCESS transfers, tracks pready wait states, and aborts with an
// error response when the slave stalls for TIMEOUT ACCESS cycles.
// One transfer is outstanding at a time; every output is a flop.
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // local command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // local response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB initiator
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Wide enough to hold TIMEOUT-1; the abort fires at that value so the
  // counter can never wrap.
  localparam int               CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic              w_last_wait;

  // Final permitted ACCESS cycle without pready.
  assign w_last_wait = (r_wait_cnt == LAST_WAIT);

  // Transfer sequencer: IDLE -> SETUP -> ACCESS (waits) -> RESP -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_cmd_ready   <= 1'b1;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_paddr     <= cmd_addr;
            r_pwrite    <= cmd_write;
            r_pwdata    <= cmd_write ? cmd_wdata : '0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= S_ACCESS;
        end

        S_ACCESS: begin
          // pready has priority over the timeout limit on the same cycle.
          if (pready) begin
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_err     <= pslverr;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else if (w_last_wait) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          // Response is held until taken; the next command waits for IDLE.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a directed vector table, a
// randomized run against a transaction-level reference model, and
// hand-written reset/backpressure sequences.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int MAX_CYC = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  apb_master_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Observed behaviour of one transfer (cycle indices are negedges from task start).
  typedef struct {
    int          acc;
    int          setup_c;
    int          rsp_c;
    int          psel_n;
    int          pen_n;
    int          addr_err;
    int          stab_err;
    int          ovl_err;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic        done;
  } obs_t;

  // Expected transfer outcome.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          pen;
  } exp_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                waits;
    logic              slverr;
    int                bp;
    logic [31:0]       exp_rdata;
    logic              exp_err;
    logic              exp_to;
    int                exp_pen;
  } vec_t;

  // Transaction-level reference: a slave that answers after 'waits' wait
  // states either completes (pen = waits+1 enable cycles) or, if that would
  // need more than TIMEOUT ACCESS cycles, gets aborted after TIMEOUT.
  function automatic exp_t model(input logic wr, input logic [31:0] rdata,
                                 input int waits, input logic slverr);
    exp_t e;
    if (waits >= TIMEOUT) begin
      e.rdata = '0; e.err = 1'b1; e.to = 1'b1; e.pen = TIMEOUT;
    end else begin
      e.rdata = wr ? 32'h0 : rdata; e.err = slverr; e.to = 1'b0; e.pen = waits + 1;
    end
    return e;
  endfunction

  // Drives one command, plays the APB slave, applies response backpressure
  // and records what the DUT did. Entered and left on a negedge.
  task automatic run_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                          input int waits, input logic slverr, input int bp,
                          input logic hold_valid, output obs_t o);
    int acc_idx;
    int n_rsp;
    logic [DATA_W-1:0] exp_pwdata;
    o.acc = -1; o.setup_c = -1; o.rsp_c = -1;
    o.psel_n = 0; o.pen_n = 0; o.addr_err = 0; o.stab_err = 0; o.ovl_err = 0;
    o.rdata = '0; o.err = 1'b0; o.to = 1'b0; o.done = 1'b0;
    acc_idx = 0;
    n_rsp = 0;
    exp_pwdata = wr ? wdata : '0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = 1'b0;
    for (int c = 0; c < MAX_CYC; c++) begin
      if (o.acc < 0) begin
        if (cmd_ready) o.acc = c;
      end else if (!hold_valid) begin
        cmd_valid = 1'b0;
      end
      if (psel) begin
        o.psel_n++;
        if (paddr !== addr || pwrite !== wr || pwdata !== exp_pwdata) o.addr_err++;
        if (!penable && o.setup_c < 0) o.setup_c = c;
      end
      if (penable) o.pen_n++;
      if (rsp_valid) begin
        n_rsp++;
        if (psel || cmd_ready) o.ovl_err++;
        if (o.rsp_c < 0) begin
          o.rsp_c = c; o.rdata = rsp_rdata; o.err = rsp_err; o.to = rsp_timeout;
        end else if (rsp_rdata !== o.rdata || rsp_err !== o.err || rsp_timeout !== o.to) begin
          o.stab_err++;
        end
        if (n_rsp > bp) begin
          rsp_ready = 1'b1;
          o.done = 1'b1;
        end
      end
      // Slave: answer on the requested ACCESS cycle, noise everywhere else.
      if (psel && penable) begin
        pready  = (acc_idx == waits);
        prdata  = pready ? rdata : $urandom;
        pslverr = pready ? slverr : 1'($urandom);
        acc_idx++;
      end else begin
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
      @(negedge clk);
      if (o.done) begin
        rsp_ready = 1'b0;
        break;
      end
    end
    pready = 1'b0;
  endtask

  task automatic verify(input string tag, input obs_t o, input exp_t e);
    check({tag, " done"},        32'(o.done), 32'd1);
    check({tag, " accept"},      o.acc, 0);
    check({tag, " setup_cycle"}, o.setup_c, o.acc + 1);
    check({tag, " penable_n"},   o.pen_n, e.pen);
    check({tag, " psel_n"},      o.psel_n, e.pen + 1);
    check({tag, " latency"},     o.rsp_c - o.acc, e.pen + 2);
    check({tag, " rdata"},       o.rdata, e.rdata);
    check({tag, " err"},         32'(o.err), 32'(e.err));
    check({tag, " timeout"},     32'(o.to), 32'(e.to));
    check({tag, " apb_stable"},  o.addr_err, 0);
    check({tag, " rsp_stable"},  o.stab_err, 0);
    check({tag, " no_overlap"},  o.ovl_err, 0);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    exp_t e;
    int   n_bad;

    vecs[0] = '{wr:1'b1, addr:12'h000, wdata:32'h0000_0103, rdata:32'h0, waits:0,
                slverr:1'b0, bp:0, exp_rdata:32'h0, exp_err:1'b0, exp_to:1'b0, exp_pen:1};
    vecs[1] = '{wr:1'b0, addr:12'h00C, wdata:32'h0, rdata:32'hFFFF_FFFF, waits:3,
                slverr:1'b0, bp:1, exp_rdata:32'hFFFF_FFFF, exp_err:1'b0, exp_to:1'b0, exp_pen:4};
    vecs[2] = '{wr:1'b0, addr:12'h014, wdata:32'h0, rdata:32'hDEAD_BEEF, waits:1,
                slverr:1'b1, bp:0, exp_rdata:32'hDEAD_BEEF, exp_err:1'b1, exp_to:1'b0, exp_pen:2};
    vecs[3] = '{wr:1'b0, addr:12'h010, wdata:32'h0, rdata:32'h1111_2222, waits:99,
                slverr:1'b0, bp:2, exp_rdata:32'h0, exp_err:1'b1, exp_to:1'b1, exp_pen:16};
    vecs[4] = '{wr:1'b0, addr:12'h018, wdata:32'h0, rdata:32'h1234_5678, waits:15,
                slverr:1'b0, bp:0, exp_rdata:32'h1234_5678, exp_err:1'b0, exp_to:1'b0, exp_pen:16};
    vecs[5] = '{wr:1'b1, addr:12'h01C, wdata:32'hCAFE_0001, rdata:32'h5555_AAAA, waits:20,
                slverr:1'b1, bp:0, exp_rdata:32'h0, exp_err:1'b1, exp_to:1'b1, exp_pen:16};
    vecs[6] = '{wr:1'b1, addr:12'h004, wdata:32'h0000_A5A5, rdata:32'h7777_7777, waits:2,
                slverr:1'b1, bp:5, exp_rdata:32'h0, exp_err:1'b1, exp_to:1'b0, exp_pen:3};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst psel",        32'(psel), 32'd0);
    check("rst penable",     32'(penable), 32'd0);
    check("rst pwrite",      32'(pwrite), 32'd0);
    check("rst paddr",       32'(paddr), 32'd0);
    check("rst pwdata",      pwdata, 32'd0);
    check("rst rsp_valid",   32'(rsp_valid), 32'd0);
    check("rst rsp_rdata",   rsp_rdata, 32'd0);
    check("rst rsp_err",     32'(rsp_err), 32'd0);
    check("rst rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst cmd_ready",   32'(cmd_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].waits,
               vecs[i].slverr, vecs[i].bp, 1'b0, o);
      e.rdata = vecs[i].exp_rdata; e.err = vecs[i].exp_err;
      e.to = vecs[i].exp_to; e.pen = vecs[i].exp_pen;
      verify($sformatf("vec%0d", i), o, e);
    end

    // Backpressure with a waiting command: held off during RESP, then
    // SETUP appears two cycles after the rsp_ready edge.
    run_xfer(1'b0, 12'h008, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 5, 1'b1, o);
    verify("bp first", o, model(1'b0, 32'h0BAD_F00D, 0, 1'b0));
    run_xfer(1'b1, 12'h00C, 32'h8765_4321, 32'h0, 1, 1'b0, 0, 1'b0, o);
    verify("bp next", o, model(1'b1, 32'h0, 1, 1'b0));

    // Reset in the middle of an ACCESS wait state.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008; pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst in_access", 32'(psel && penable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst psel",      32'(psel), 32'd0);
    check("midrst penable",   32'(penable), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    n_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || psel) n_bad++;
      @(negedge clk);
    end
    check("midrst no_response", n_bad, 0);

    // Randomized transfers against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata, rdata;
      int          waits;
      logic        slverr;
      wr     = 1'($urandom);
      addr   = 12'($urandom);
      wdata  = $urandom;
      rdata  = $urandom;
      waits  = $urandom_range(0, 19);
      slverr = 1'($urandom);
      run_xfer(wr, addr, wdata, rdata, waits, slverr, $urandom_range(0, 3),
               1'($urandom), o);
      verify($sformatf("rand%0d", i), o, model(wr, rdata, waits, slverr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
